// File: rtl/alu_ctrl_fsm.sv
// Multicycle control unit for an RV32I-subset datapath.
// Walks each instruction through fetch, decode, execute, memory and
// writeback. Each cycle it produces the ALU select code, the datapath mux
// selects and the write strobes. It stalls on mem_ready while waiting for
// a memory access.
//
// Handshake: mem_ready is a single-cycle completion indication. When
// mem_ready=1 is seen in a memory-waiting state (FETCH, MEMRD, MEMWR), the
// current access completes on that clock edge. While waiting, the request
// (mem_read or mem_write) is held high. mem_ready is ignored in all other
// states.
module alu_ctrl_fsm #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_select,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    EXEC_I = 4'd7,
    ALUWB  = 4'd8,
    BEQ    = 4'd9,
    HALT   = 4'd10
  } state_t;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU select codes in the datapath encoding
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;
  localparam logic [2:0] ALU_SHR  = 3'b110;

  // Mux select encodings
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  state_t     state_q;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] funct_op;
  logic       funct_ok;
  logic       is_load;
  logic       is_store;
  logic       is_rtype;
  logic       is_itype;
  logic       is_beq;

  // Only the opcode and funct3 fields take part in decoding
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[WIDTH-1:15], instr[11:7]};

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_itype = (opcode == OP_ITYPE);
  assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);

  // funct3 to ALU operation; 010/011 (slt/sltu) have no ALU support
  always_comb begin
    funct_op = 3'b000;
    funct_ok = 1'b1;
    case (funct3)
      3'b000:  funct_op = ALU_ADD;
      3'b111:  funct_op = ALU_AND;
      3'b110:  funct_op = ALU_OR;
      3'b100:  funct_op = ALU_XOR;
      3'b001:  funct_op = ALU_SHL;
      3'b101:  funct_op = ALU_SHR;
      default: funct_ok = 1'b0;
    endcase
  end

  // State register and sticky illegal flag; HALT is left only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) state_q <= DECODE;
        end
        DECODE: begin
          if (is_load || is_store) begin
            state_q <= MEMADR;
          end else if (is_rtype && funct_ok) begin
            state_q <= EXEC_R;
          end else if (is_itype && funct_ok) begin
            state_q <= EXEC_I;
          end else if (is_beq) begin
            state_q <= BEQ;
          end else begin
            state_q   <= HALT;
            illegal_q <= 1'b1;
          end
        end
        MEMADR: begin
          state_q <= is_load ? MEMRD : MEMWR;
        end
        MEMRD: begin
          if (mem_ready) state_q <= MEMWB;
        end
        MEMWB: begin
          state_q <= FETCH;
        end
        MEMWR: begin
          if (mem_ready) state_q <= FETCH;
        end
        EXEC_R, EXEC_I: begin
          state_q <= ALUWB;
        end
        ALUWB, BEQ: begin
          state_q <= FETCH;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          // Unused encodings are treated as a fault and parked in HALT
          state_q   <= HALT;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  // Per-state datapath controls; write strobes are suppressed during reset
  always_comb begin
    alu_select = 3'b000;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_select = ALU_ADD;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        // Precompute the branch target into the ALU-out register
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        alu_select = ALU_ADD;
      end
      MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_select = ALU_ADD;
      end
      MEMRD: begin
        mem_read = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEMDATA;
      end
      MEMWR: begin
        mem_write = 1'b1;
      end
      EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_select = funct_op;
      end
      EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_select = funct_op;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
      end
      BEQ: begin
        // rs1 ^ rs2 is zero exactly when the operands are equal
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_select = ALU_XOR;
        result_src = RES_ALUOUT;
        pc_write   = zero;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle control unit that drives the datapath ALU and its surrounding muxes and write enables.
- Decodes the RV32I subset held in the instruction register and issues the ALU select code in the datapath encoding: 001 add, 010 and, 011 or, 100 xor, 101 shl-by-1, 110 shr-by-1, 111 xnor.
- Consumes the ALU zero flag for branch resolution, so it is the control-side end of the ALU interface.
- Stalls on a memory-ready handshake.

Parameters:
- WIDTH, 32, instruction width. Only bits [14:12] and [6:0] are decoded.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr  in  WIDTH  current instruction register contents
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- alu_select  out  3  ALU operation code
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- result_src  out  2  00 ALU-out register, 01 memory data, 10 ALU result
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- illegal  out  1  unsupported instruction, sticky
- state  out  4  current state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, HALT=10.
- Outputs are combinational from state. Any output not listed for a state is 0.
- Reset: on a clk edge with rst_n=0, state becomes FETCH and the illegal register clears. While rst_n=0, mem_write, reg_write, pc_write and ir_write are forced to 0 in the same cycle, regardless of state.
- FETCH: mem_read=1, src_a=00, src_b=10, select=001, result_src=10.
  - mem_ready=0: hold in FETCH with no strobes.
  - mem_ready=1: ir_write=1 and pc_write=1 in that cycle; next state DECODE.
- DECODE: src_a=01, src_b=01, select=001 (branch target into ALU-out). Next state by opcode instr[6:0]:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 with funct3=000 -> BEQ
  - anything else -> HALT
- funct3 map for EXEC_R and EXEC_I:
  - 000 -> 001
  - 111 -> 010
  - 110 -> 011
  - 100 -> 100
  - 001 -> 101
  - 101 -> 110
  - funct3 010 or 011 on opcode 0110011/0010011 -> DECODE goes to HALT instead.
- MEMADR: src_a=10, src_b=01, select=001. Next state MEMRD for a load, MEMWR for a store.
- MEMRD: mem_read=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, result_src=01. Next state FETCH.
- MEMWR: mem_write=1. Hold until mem_ready=1, then FETCH. mem_write stays high for every stall cycle.
- EXEC_R: src_a=10, src_b=00, select from funct3 map. Next state ALUWB.
- EXEC_I: src_a=10, src_b=01, select from funct3 map. Next state ALUWB.
- ALUWB: reg_write=1, result_src=00. Next state FETCH.
- BEQ: src_a=10, src_b=00, select=100 (xor), result_src=00, pc_write=zero. Next state FETCH.
- HALT: illegal=1, all strobes 0. Stays in HALT until reset.
- Instruction latency in cycles, with no memory stalls:
  - R-type and I-type: 4
  - load: 5
  - store: 4
  - branch: 3
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset mid-operation, e.g. during a MEMWR stall: returns to FETCH on the next edge, and no write strobe is asserted during the reset cycle.

Test Plan:
- Reset, then mem_ready=1 and instr=0x002081B3 (add x3,x1,x2) -> states 0,1,6,8,0. alu_select=001 in EXEC_R; reg_write=1 only in ALUWB with result_src=00.
- instr=0x0000C093 (xori), then funct3 sweep 000/111/110/100/001/101 on opcode 0010011 -> EXEC_I alu_select 001/010/011/100/101/110 respectively, src_b=01.
- Load 0x0000A183 with mem_ready low for 3 cycles in MEMRD -> state holds 3 at mem_read=1; total 8 cycles FETCH-to-FETCH; reg_write with result_src=01 exactly once.
- Branch 0x00208463: zero=1 -> pc_write=1 in BEQ with select=100; repeat with zero=0 -> pc_write=0 in BEQ; both return to FETCH after 3 cycles.
- Opcode 0x7F, or opcode 0110011 with funct3=010 -> HALT; illegal=1 persists for 20 cycles with no strobes; rst_n=0 for one edge -> state 0, illegal=0.
- Store 0x0020A023, rst_n driven low during a MEMWR stall -> mem_write=0 in that cycle, state=FETCH on the next edge, and no reg_write ever.
